seven_seg_scan_capture: RTL and testbench

Test-support monitor that watches a multiplexed, time-scanned seven-segment display bus (shared segment lines plus one anode per digit) and reconstructs the full multi-digit hexadecimal value being shown. It decodes each digit back to a nibble, tracks decimal points, blanks and unrecognised patterns, and publishes a value only after it has been identical for a configurable number of complete scans. It sits beside the display driver in testbenches and on-board self-check harnesses. It is never in the display path.

---
 rtl/seven_seg_scan_capture.sv | 209 ++++++++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_capture.sv
// Passive monitor for a time-multiplexed seven-segment bus: rebuilds the displayed
// hex value digit by digit and publishes it once it has stayed identical across scans.
module seven_seg_scan_capture #(
    parameter int DIGITS           = 4,
    parameter int SETTLE           = 2,
    parameter int STABLE_SCANS     = 2,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DIGITS-1:0]     anodes,
    input  logic [7:0]            segments,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     error,
    output logic                  valid,
    output logic                  scan_done,
    output logic                  ghost
);

    localparam int CW = $clog2(STABLE_SCANS + 1);
    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [DIGITS-1:0] ANODE_IDLE = ANODE_ACTIVE_LOW ? '1 : '0;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } state_t;

    // Returns {error, blank, nibble} for the active-low g..a segment lines.
    function automatic logic [5:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h40:   decode_seg = {2'b00, 4'h0};
            7'h79:   decode_seg = {2'b00, 4'h1};
            7'h24:   decode_seg = {2'b00, 4'h2};
            7'h30:   decode_seg = {2'b00, 4'h3};
            7'h19:   decode_seg = {2'b00, 4'h4};
            7'h12:   decode_seg = {2'b00, 4'h5};
            7'h02:   decode_seg = {2'b00, 4'h6};
            7'h78:   decode_seg = {2'b00, 4'h7};
            7'h00:   decode_seg = {2'b00, 4'h8};
            7'h18:   decode_seg = {2'b00, 4'h9};
            7'h08:   decode_seg = {2'b00, 4'hA};
            7'h03:   decode_seg = {2'b00, 4'hB};
            7'h46:   decode_seg = {2'b00, 4'hC};
            7'h21:   decode_seg = {2'b00, 4'hD};
            7'h06:   decode_seg = {2'b00, 4'hE};
            7'h0E:   decode_seg = {2'b00, 4'hF};
            7'h3F:   decode_seg = {2'b00, 4'hD};
            7'h7F:   decode_seg = {2'b01, 4'hE};
            default: decode_seg = {2'b10, 4'hF};
        endcase
    endfunction

    logic [DIGITS-1:0]   anodes_q;
    logic [7:0]          segments_q;
    logic [DIGITS-1:0]   act;
    logic [DIGITS-1:0]   act_last;
    logic                one_hot;
    logic                multi;
    logic                changed;

    state_t              state, state_n;
    logic [SW-1:0]       settle_cnt, settle_cnt_n;
    logic                capture;
    logic                enter;

    logic [5:0]          dec;
    logic [DIGITS-1:0]   seen, seen_cap;
    logic [4*DIGITS-1:0] sh_value, sh_value_n, pv_value;
    logic [DIGITS-1:0]   sh_dp, sh_dp_n, pv_dp;
    logic [DIGITS-1:0]   sh_blank, sh_blank_n, pv_blank;
    logic [DIGITS-1:0]   sh_error, sh_error_n, pv_error;
    logic                first_done;
    logic [CW-1:0]       stable_cnt, stable_n;
    logic                done;
    logic                match;
    logic                publish;

    assign act     = ANODE_ACTIVE_LOW ? ~anodes_q : anodes_q;
    assign one_hot = (act != '0) && ((act & (act - DIGITS'(1))) == '0);
    assign multi   = (act != '0) && !one_hot;
    assign changed = (act != act_last);
    assign dec     = decode_seg(segments_q[6:0]);

    // The anode register idles at "no digit selected" so reset never looks like a ghost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            anodes_q   <= ANODE_IDLE;
            segments_q <= '0;
            act_last   <= '0;
            state      <= ST_WAIT;
            settle_cnt <= '0;
            ghost      <= 1'b0;
        end else begin
            anodes_q   <= anodes;
            segments_q <= segments;
            act_last   <= act;
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            ghost      <= multi;
        end
    end

    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        capture      = 1'b0;
        enter        = 1'b0;
        case (state)
            ST_WAIT: enter = one_hot;
            default: begin
                if (changed) begin
                    if (one_hot) enter = 1'b1;
                    else         state_n = ST_WAIT;
                end else if (state == ST_SETTLE) begin
                    if (int'(settle_cnt) + 1 >= SETTLE) begin
                        capture = 1'b1;
                        state_n = ST_HELD;
                    end else begin
                        settle_cnt_n = settle_cnt + SW'(1);
                    end
                end
            end
        endcase
        if (enter) begin
            if (SETTLE <= 1) begin
                capture = 1'b1;
                state_n = ST_HELD;
            end else begin
                state_n      = ST_SETTLE;
                settle_cnt_n = SW'(1);
            end
        end
    end

    always_comb begin
        sh_value_n = sh_value;
        sh_dp_n    = sh_dp;
        sh_blank_n = sh_blank;
        sh_error_n = sh_error;
        for (int k = 0; k < DIGITS; k++) begin
            if (capture && act[k]) begin
                sh_value_n[4*k +: 4] = dec[3:0];
                sh_blank_n[k]        = dec[4];
                sh_error_n[k]        = dec[5];
                sh_dp_n[k]           = ~segments_q[7];
            end
        end
        seen_cap = seen | (capture ? act : '0);
        done     = capture && (seen_cap == '1);
        match    = first_done && (sh_value_n == pv_value) && (sh_dp_n == pv_dp) &&
                   (sh_blank_n == pv_blank) && (sh_error_n == pv_error);
        stable_n = match ? ((&stable_cnt) ? stable_cnt : stable_cnt + CW'(1)) : CW'(1);
        publish  = done && (int'(stable_n) >= STABLE_SCANS);
    end

    // Shadow collects the current scan; previous-scan copy and publishing update on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen       <= '0;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            sh_error   <= '0;
            pv_value   <= '0;
            pv_dp      <= '0;
            pv_blank   <= '0;
            pv_error   <= '0;
            first_done <= 1'b0;
            stable_cnt <= '0;
            scan_done  <= 1'b0;
            value      <= '0;
            dp         <= '0;
            blank      <= '0;
            error      <= '0;
            valid      <= 1'b0;
        end else begin
            sh_value  <= sh_value_n;
            sh_dp     <= sh_dp_n;
            sh_blank  <= sh_blank_n;
            sh_error  <= sh_error_n;
            scan_done <= done;
            if (done) begin
                seen       <= '0;
                pv_value   <= sh_value_n;
                pv_dp      <= sh_dp_n;
                pv_blank   <= sh_blank_n;
                pv_error   <= sh_error_n;
                first_done <= 1'b1;
                stable_cnt <= stable_n;
                if (publish) begin
                    value <= sh_value_n;
                    dp    <= sh_dp_n;
                    blank <= sh_blank_n;
                    error <= sh_error_n;
                    valid <= 1'b1;
                end else if (!match) begin
                    valid <= 1'b0;
                end
            end else begin
                seen <= seen_cap;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed bench for seven_seg_scan_capture: drives scans of a 4-digit active-low display
// and checks each scan_done against a scoreboard filled by a behavioural model.
module tb_seven_seg_scan_capture;

    logic        clk;
    logic        reset_n;
    logic [3:0]  anodes;
    logic [7:0]  segments;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  error;
    logic        valid;
    logic        scan_done;
    logic        ghost;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  error;
        logic        valid;
    } exp_t;

    exp_t scb[$];
    exp_t got_e;
    exp_t m_prev;
    exp_t m_pub;
    bit   m_have_prev;
    int   m_cnt;
    int   exp_done;
    int   done_cnt;
    int   ghost_cnt;
    int   vectors;
    int   miscompares;

    seven_seg_scan_capture dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .anodes    (anodes),
        .segments  (segments),
        .value     (value),
        .dp        (dp),
        .blank     (blank),
        .error     (error),
        .valid     (valid),
        .scan_done (scan_done),
        .ghost     (ghost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {dp, error, blank, nibble} for a raw segment byte.
    function automatic logic [6:0] ref_decode(input logic [7:0] seg);
        logic [6:0] s;
        logic [5:0] r;
        s = seg[6:0];
        case (s)
            7'h40: r = 6'h00;  7'h79: r = 6'h01;  7'h24: r = 6'h02;  7'h30: r = 6'h03;
            7'h19: r = 6'h04;  7'h12: r = 6'h05;  7'h02: r = 6'h06;  7'h78: r = 6'h07;
            7'h00: r = 6'h08;  7'h18: r = 6'h09;  7'h08: r = 6'h0A;  7'h03: r = 6'h0B;
            7'h46: r = 6'h0C;  7'h21: r = 6'h0D;  7'h06: r = 6'h0E;  7'h0E: r = 6'h0F;
            7'h3F: r = 6'h0D;
            7'h7F: r = 6'h1E;
            default: r = 6'h2F;
        endcase
        return {~seg[7], r};
    endfunction

    task automatic model_reset();
        m_have_prev = 1'b0;
        m_cnt       = 0;
        m_pub       = '0;
        m_prev      = '0;
    endtask

    task automatic model_scan(input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
        logic [7:0] segs [4];
        logic [6:0] r;
        exp_t       sh;
        bit         match;
        segs[0] = d0; segs[1] = d1; segs[2] = d2; segs[3] = d3;
        sh = '0;
        for (int k = 0; k < 4; k++) begin
            r = ref_decode(segs[k]);
            sh.value[4*k +: 4] = r[3:0];
            sh.blank[k]        = r[4];
            sh.error[k]        = r[5];
            sh.dp[k]           = r[6];
        end
        match = m_have_prev && (sh == m_prev);
        m_cnt = match ? m_cnt + 1 : 1;
        if (m_cnt >= 2) begin
            m_pub       = sh;
            m_pub.valid = 1'b1;
        end else if (!match) begin
            m_pub.valid = 1'b0;
        end
        m_prev      = sh;
        m_have_prev = 1'b1;
        scb.push_back(m_pub);
        exp_done++;
    endtask

    task automatic show_digit(input int k, input logic [7:0] seg, input int cycles);
        anodes   = 4'(~(4'b0001 << k));
        segments = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d3, input logic [7:0] d2,
                                 input logic [7:0] d1, input logic [7:0] d0);
        model_scan(d3, d2, d1, d0);
        show_digit(3, d3, 4);
        show_digit(2, d2, 4);
        show_digit(1, d1, 4);
        show_digit(0, d0, 4);
        anodes = 4'hF;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_value"}, 32'(value), 32'h0);
        checkOutput({tag, "_dp"}, 32'(dp), 32'h0);
        checkOutput({tag, "_blank"}, 32'(blank), 32'h0);
        checkOutput({tag, "_error"}, 32'(error), 32'h0);
        checkOutput({tag, "_valid"}, 32'(valid), 32'h0);
        checkOutput({tag, "_scan_done"}, 32'(scan_done), 32'h0);
        checkOutput({tag, "_ghost"}, 32'(ghost), 32'h0);
    endtask

    always @(negedge clk) begin
        if (ghost) ghost_cnt++;
        if (scan_done) begin
            done_cnt++;
            vectors++;
            assert (scb.size() != 0) else begin
                miscompares++;
                $error("[TB] FAIL unexpected_scan_done: observed pulse %0d expected none queued", done_cnt);
            end
            if (scb.size() != 0) begin
                got_e = scb.pop_front();
                checkOutput("scan_value", 32'(value), 32'(got_e.value));
                checkOutput("scan_dp", 32'(dp), 32'(got_e.dp));
                checkOutput("scan_blank", 32'(blank), 32'(got_e.blank));
                checkOutput("scan_error", 32'(error), 32'(got_e.error));
                checkOutput("scan_valid", 32'(valid), 32'(got_e.valid));
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_done    = 0;
        done_cnt    = 0;
        ghost_cnt   = 0;
        model_reset();
        reset_n  = 1'b0;
        anodes   = 4'hF;
        segments = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        $display("[TB] scanning 12AF three times");
        repeat (3) applyStimulus(8'hF9, 8'hA4, 8'h88, 8'h8E);
        checkOutput("t1_done_count", 32'(done_cnt), 32'(exp_done));
        checkOutput("t1_no_ghost", 32'(ghost_cnt), 32'h0);

        $display("[TB] digit 0 changes to 0");
        repeat (2) applyStimulus(8'hF9, 8'hA4, 8'h88, 8'hC0);

        $display("[TB] blank on digit 2, unknown pattern on digit 1");
        repeat (2) applyStimulus(8'hF9, 8'h7F, 8'h55, 8'hC0);

        $display("[TB] ghosting in the middle of a scan");
        model_scan(8'hF9, 8'h7F, 8'h55, 8'hC0);
        show_digit(3, 8'hF9, 4);
        show_digit(2, 8'h7F, 4);
        ghost_cnt = 0;
        anodes    = 4'b1100;
        segments  = 8'h8E;
        repeat (5) @(posedge clk);
        #1;
        show_digit(1, 8'h55, 4);
        show_digit(0, 8'hC0, 4);
        anodes = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_ghost_cycles", 32'(ghost_cnt), 32'd5);
        checkOutput("t4_done_count", 32'(done_cnt), 32'(exp_done));

        $display("[TB] digits shown too briefly");
        for (int r = 0; r < 3; r++) begin
            for (int k = 3; k >= 0; k--) show_digit(k, 8'hA4, 1);
        end
        anodes = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t5_no_capture", 32'(done_cnt), 32'(exp_done));
        checkOutput("t5_value_held", 32'(value), 32'h1EF0);

        $display("[TB] reset in the middle of a scan");
        show_digit(3, 8'hF9, 4);
        show_digit(2, 8'hA4, 4);
        anodes   = 4'b1101;
        segments = 8'h88;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        anodes = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) applyStimulus(8'hF9, 8'hA4, 8'h88, 8'h8E);

        repeat (4) @(posedge clk);
        #1;
        checkOutput("final_done_count", 32'(done_cnt), 32'(exp_done));
        checkOutput("final_scoreboard_left", 32'(scb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
